// File: rtl/handshake_rx_mc.sv
// handshake_rx_mc: multi-channel four-phase req/ack receiver.
// Each channel's request is synchronised into clk, channels are granted one
// at a time in round-robin order, and the granted channel's word is emitted
// as a one-cycle dvalid pulse tagged with its channel index.
// Optional feature macro: HS_TIMEOUT_EN (abort a grant whose request never
// releases within TIMEOUT cycles and pulse err).
module handshake_rx_mc #(
  parameter int WIDTH       = 8,
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CH-1:0]                 sreq,
  input  logic [CH*WIDTH-1:0]           sdata,
  input  logic                          dbusy,
  output logic [CH-1:0]                 dack,
  output logic                          dvalid,
  output logic [WIDTH-1:0]              dout,
  output logic [((CH>1)?$clog2(CH):1)-1:0] dch,
  output logic                          didle,
  output logic                          err
);

  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CW:0]   CH_V    = (CW+1)'(CH);
  localparam logic [CW-1:0] LAST_CH = CW'(CH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  // Illegal parameter combinations elaborate an obviously dead block so they
  // stand out in the hierarchy.
  if (CH < 2 || SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_badParams
    logic w_badParams;
    assign w_badParams = 1'b1;
  end

  logic [CH-1:0]    r_sync [SYNC_STAGES];
  logic [CH-1:0]    w_dreq;
  logic [1:0]       r_state;
  logic [CW-1:0]    r_g;
  logic [CW-1:0]    r_ptr;
  logic [CW-1:0]    w_ptrNext;
  logic [WIDTH-1:0] r_word;
  logic [CH-1:0]    r_dack;
  logic             r_dvalid;
  logic [WIDTH-1:0] r_dout;
  logic [CW-1:0]    r_dch;
  logic             w_found;
  logic [CW-1:0]    w_sel;
  logic [CW:0]      w_idx;
  logic [WIDTH-1:0] w_selData;

`ifdef HS_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] r_tcnt;
  logic          r_err;
`endif

  assign w_dreq = r_sync[SYNC_STAGES-1];

  // Request synchronisers: SYNC_STAGES flops per channel, reset to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= sreq;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  // Round-robin pick: first synchronised request at or after ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 0; k < CH; k++) begin
      w_idx = {1'b0, r_ptr} + (CW+1)'(k);
      if (w_idx >= CH_V) w_idx = w_idx - CH_V;
      if (!w_found && w_dreq[w_idx[CW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[CW-1:0];
      end
    end
  end

  // Data word of the channel about to be granted.
  always_comb begin
    w_selData = '0;
    for (int k = 0; k < CH; k++) begin
      if (w_sel == CW'(k)) w_selData = sdata[k*WIDTH +: WIDTH];
    end
  end

  assign w_ptrNext = (r_g == LAST_CH) ? '0 : r_g + 1'b1;

  // Grant FSM: IDLE picks a channel, ACK waits for its request to drop,
  // OUT retires the transfer and advances the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_g      <= '0;
      r_ptr    <= '0;
      r_word   <= '0;
      r_dack   <= '0;
      r_dvalid <= 1'b0;
      r_dout   <= '0;
      r_dch    <= '0;
`ifdef HS_TIMEOUT_EN
      r_tcnt   <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_dvalid <= 1'b0;
`ifdef HS_TIMEOUT_EN
      r_err    <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (!dbusy && w_found) begin
            r_g           <= w_sel;
            r_dack[w_sel] <= 1'b1;
            r_word        <= w_selData;
            r_state       <= S_ACK;
`ifdef HS_TIMEOUT_EN
            r_tcnt        <= '0;
`endif
          end
        end
        S_ACK: begin
          if (!w_dreq[r_g]) begin
            r_dack   <= '0;
            r_dout   <= r_word;
            r_dch    <= r_g;
            r_dvalid <= 1'b1;
            r_state  <= S_OUT;
          end
`ifdef HS_TIMEOUT_EN
          else if (r_tcnt == TW'(TIMEOUT - 1)) begin
            r_dack  <= '0;
            r_err   <= 1'b1;
            r_ptr   <= w_ptrNext;
            r_state <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
`endif
        end
        S_OUT: begin
          r_ptr   <= w_ptrNext;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dack   = r_dack;
  assign dvalid = r_dvalid;
  assign dout   = r_dout;
  assign dch    = r_dch;
  assign didle  = (r_state == S_IDLE);
`ifdef HS_TIMEOUT_EN
  assign err    = r_err;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_handshake_rx_mc.sv
// tb_handshake_rx_mc: self-checking bench for handshake_rx_mc (CH=4,
// WIDTH=8, SYNC_STAGES=2). A transaction-level model predicts the order in
// which simultaneously requesting channels are served from the RR pointer.
`timescale 1ns/1ps
module tb_handshake_rx_mc;

  localparam int CH = 4;
  localparam int WIDTH = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   sreq;
  logic [CH*WIDTH-1:0] sdata;
  logic            dbusy;
  wire  [CH-1:0]   dack;
  wire             dvalid;
  wire  [WIDTH-1:0] dout;
  wire  [1:0]      dch;
  wire             didle;
  wire             err;

  int compared = 0;
  int mismatched = 0;
  int modelPtr = 0;

  handshake_rx_mc #(.WIDTH(WIDTH), .CH(CH), .SYNC_STAGES(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .sreq(sreq), .sdata(sdata), .dbusy(dbusy),
    .dack(dack), .dvalid(dvalid), .dout(dout), .dch(dch), .didle(didle), .err(err)
  );

  // 100 MHz destination clock.
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; sreq = '0; sdata = '0; dbusy = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (dack !== 4'b0) begin mismatched++; $display("[TB] FAIL reset_dack got=%b exp=0000", dack); end
    compared++; if (dvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dvalid got=%b exp=0", dvalid); end
    compared++; if (dout !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_dout got=%h exp=00", dout); end
    compared++; if (dch !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_dch got=%0d exp=0", dch); end
    compared++; if (didle !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_didle got=%b exp=1", didle); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
    rst_n = 1'b1;
    modelPtr = 0;
    @(negedge clk);
  endtask

  // Wait up to maxCycles negedges for dvalid; returns 1 when seen.
  task automatic waitValid(input int maxCycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      @(negedge clk);
      if (dvalid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_single();
    bit seen;
    sdata[2*WIDTH +: WIDTH] = 8'hA5;
    sreq[2] = 1'b1;
    @(negedge clk);
    compared++; if (dack !== 4'b0000) begin mismatched++; $display("[TB] FAIL single_lat1 got=%b exp=0000", dack); end
    @(negedge clk);
    compared++; if (dack !== 4'b0000) begin mismatched++; $display("[TB] FAIL single_lat2 got=%b exp=0000", dack); end
    @(negedge clk);
    compared++; if (dack !== 4'b0100) begin mismatched++; $display("[TB] FAIL single_ack got=%b exp=0100", dack); end
    sreq[2] = 1'b0;
    waitValid(12, seen);
    compared++; if (!seen) begin mismatched++; $display("[TB] FAIL single_dvalid got=none exp=pulse"); end
    compared++; if (dout !== 8'hA5) begin mismatched++; $display("[TB] FAIL single_dout got=%h exp=a5", dout); end
    compared++; if (dch !== 2'd2) begin mismatched++; $display("[TB] FAIL single_dch got=%0d exp=2", dch); end
    compared++; if (dack !== 4'b0000) begin mismatched++; $display("[TB] FAIL single_ackdrop got=%b exp=0000", dack); end
    @(negedge clk);
    compared++; if (dvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_pulse got=%b exp=0", dvalid); end
    compared++; if (didle !== 1'b1) begin mismatched++; $display("[TB] FAIL single_idle got=%b exp=1", didle); end
    modelPtr = 3;
  endtask

  task automatic test_backpressure();
    bit seen;
    bit anyAck;
    dbusy = 1'b1;
    sdata[1*WIDTH +: WIDTH] = 8'h3C;
    sreq[1] = 1'b1;
    anyAck = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (dack !== 4'b0000) anyAck = 1'b1;
    end
    compared++; if (anyAck) begin mismatched++; $display("[TB] FAIL busy_noack got=ack exp=none"); end
    compared++; if (didle !== 1'b1) begin mismatched++; $display("[TB] FAIL busy_idle got=%b exp=1", didle); end
    dbusy = 1'b0;
    @(negedge clk);
    compared++; if (dack !== 4'b0010) begin mismatched++; $display("[TB] FAIL busy_release got=%b exp=0010", dack); end
    sreq[1] = 1'b0;
    waitValid(12, seen);
    compared++; if (!seen || dch !== 2'd1 || dout !== 8'h3C) begin
      mismatched++; $display("[TB] FAIL busy_xfer got=seen%0d ch%0d %h exp=seen1 ch1 3c", seen, dch, dout);
    end
    @(negedge clk);
    modelPtr = 2;
  endtask

  // Raise every channel in mask together and compare the served sequence
  // with the round-robin order predicted from modelPtr.
  task automatic runBatch(input logic [CH-1:0] mask, input logic [CH*WIDTH-1:0] words, input string name);
    int expCh[$];
    logic [WIDTH-1:0] expD[$];
    int obsCh[$];
    logic [WIDTH-1:0] obsD[$];
    int phase[CH];
    int cycles;
    bit done;
    for (int k = 0; k < CH; k++) begin
      int c;
      c = (modelPtr + k) % CH;
      if (mask[c]) begin
        expCh.push_back(c);
        expD.push_back(words[c*WIDTH +: WIDTH]);
      end
    end
    for (int c = 0; c < CH; c++) begin
      if (mask[c]) sdata[c*WIDTH +: WIDTH] = words[c*WIDTH +: WIDTH];
      phase[c] = mask[c] ? 1 : 3;
    end
    sreq = sreq | mask;
    cycles = 0;
    done = 1'b0;
    while (!done && cycles < 300) begin
      @(negedge clk);
      cycles++;
      compared++; if ($countones(dack) > 1) begin mismatched++; $display("[TB] FAIL %s_onehot got=%b exp=<=1 bit", name, dack); end
      compared++; if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL %s_err got=%b exp=0", name, err); end
      if (dvalid === 1'b1) begin
        obsCh.push_back(int'(dch));
        obsD.push_back(dout);
      end
      for (int c = 0; c < CH; c++) begin
        if (phase[c] == 1 && dack[c] === 1'b1) begin
          sreq[c] = 1'b0;
          phase[c] = 2;
        end else if (phase[c] == 2 && dack[c] === 1'b0) begin
          phase[c] = 3;
        end
      end
      done = (obsCh.size() == expCh.size());
      for (int c = 0; c < CH; c++) if (phase[c] != 3) done = 1'b0;
    end
    compared++; if (!done) begin mismatched++; $display("[TB] FAIL %s_timeout got=%0d xfers exp=%0d", name, obsCh.size(), expCh.size()); end
    for (int i = 0; i < expCh.size() && i < obsCh.size(); i++) begin
      compared++;
      if (obsCh[i] !== expCh[i] || obsD[i] !== expD[i]) begin
        mismatched++;
        $display("[TB] FAIL %s_item%0d got=ch%0d %h exp=ch%0d %h", name, i, obsCh[i], obsD[i], expCh[i], expD[i]);
      end
    end
    if (expCh.size() > 0) modelPtr = (expCh[expCh.size()-1] + 1) % CH;
  endtask

  task automatic test_fairness();
    runBatch(4'b1000, 32'h99000000, "fair_ch3");
    runBatch(4'b1010, 32'h77005500, "fair_pair");
  endtask

  task automatic test_contention();
    runBatch(4'b1011, 32'h44002211, "contend");
  endtask

  task automatic test_reset_mid_ack();
    bit got;
    bit stale;
    sdata[2*WIDTH +: WIDTH] = 8'hE7;
    sreq[2] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (dack[2] === 1'b1) got = 1'b1;
    end
    compared++; if (!got) begin mismatched++; $display("[TB] FAIL rstmid_grant got=none exp=dack2"); end
    #2 rst_n = 1'b0;
    #1;
    compared++; if (dack !== 4'b0 || dvalid !== 1'b0 || dout !== 8'h00 || didle !== 1'b1) begin
      mismatched++; $display("[TB] FAIL rstmid_clear got=ack%b v%b d%h idle%b exp=ack0000 v0 d00 idle1", dack, dvalid, dout, didle);
    end
    sreq[2] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (dvalid !== 1'b0 || dack !== 4'b0) stale = 1'b1;
    end
    compared++; if (stale) begin mismatched++; $display("[TB] FAIL rstmid_stale got=activity exp=quiet"); end
    modelPtr = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      logic [CH-1:0] m;
      logic [CH*WIDTH-1:0] w;
      m = CH'($urandom_range(1, 15));
      w = $urandom;
      runBatch(m, w, "rand");
    end
  endtask

`ifdef HS_TIMEOUT_EN
  task automatic test_timeout();
    bit got;
    bit sawValid;
    int high;
    sdata[WIDTH-1:0] = 8'h5A;
    sreq[0] = 1'b1;
    got = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (dack[0] === 1'b1) got = 1'b1;
    end
    high = 1;
    while (got && dack[0] === 1'b1 && high < 40) begin
      @(negedge clk);
      if (dvalid === 1'b1) sawValid = 1'b1;
      if (dack[0] === 1'b1) high++;
    end
    compared++; if (high !== 8) begin mismatched++; $display("[TB] FAIL timeout_len got=%0d exp=8", high); end
    compared++; if (err !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_err got=%b exp=1", err); end
    compared++; if (sawValid) begin mismatched++; $display("[TB] FAIL timeout_dvalid got=pulse exp=none"); end
    sreq[0] = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    modelPtr = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_fairness();
    test_contention();
    test_reset_mid_ack();
    test_random();
`ifdef HS_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/handshake_rx_mc.md
Name: handshake_rx_mc

Overview:
- Destination-side receiver for CH independent four-phase req/ack handshake channels originating in a foreign clock domain.
- Synchronises each incoming request internally, grants one channel at a time by round-robin, and captures that channel's data word.
- Drives the per-channel acknowledge back and presents the word as a one-cycle dvalid pulse tagged with its channel number.
- Multi-channel, depth-configurable successor to the single-channel handshake synchroniser; sits at the clk-domain edge of multi-source CDC paths.

Parameters:
- WIDTH, 8, data bits per channel.
- CH, 4, number of request channels (>=2).
- SYNC_STAGES, 2, flops per request synchroniser chain (>=2).
- TIMEOUT, 255, max cycles waiting for request release (used only with HS_TIMEOUT_EN; >=1).

Ports:
- clk  input  1  destination clock.
- rst_n  input  1  asynchronous active-low reset.
- sreq  input  CH  per-channel requests, asynchronous to clk.
- sdata  input  CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]; source-stable from before sreq[i] rises until sreq[i] falls.
- dbusy  input  1  downstream busy; blocks new grants.
- dack  output  CH  per-channel acknowledge, registered.
- dvalid  output  1  one-cycle output-valid pulse.
- dout  output  WIDTH  received word.
- dch  output  max(1,$clog2(CH))  channel index of dout.
- didle  output  1  high when FSM is in IDLE.
- err  output  1  timeout pulse; constant 0 without HS_TIMEOUT_EN.

Behaviour:
- Reset: all sync flops, dack, dvalid, dout, dch, err, grant register g and RR pointer ptr go to 0; FSM goes to IDLE. Reset mid-transaction aborts it silently; sources see dack=0.
- Synchronisers: dreq[i] = sreq[i] delayed through SYNC_STAGES flops. FSM and data capture use only dreq, never raw sreq.
- States: IDLE, ACK, OUT.
- IDLE:
  - If dbusy=0 and any dreq bit is set, choose g = first set index searching ptr, ptr+1, ..., wrapping mod CH.
  - On that edge: dack[g]<=1, capture data word <= sdata[g], go to ACK.
  - Otherwise stay in IDLE. dbusy=1 holds IDLE regardless of dreq.
- ACK:
  - Hold dack[g]=1 while dreq[g]=1.
  - When dreq[g]=0: dack[g]<=0, dout<=captured word, dch<=g, dvalid<=1, go to OUT.
  - dbusy is ignored once granted.
- OUT:
  - dvalid<=0, ptr<=(g+1) mod CH, go to IDLE.
  - dout and dch hold their values until the next transfer.
- At most one dack bit is high at any time.
- A channel whose dreq is still high because its source has not yet seen dack fall cannot re-win until its request cycles low, then high again.
- Latency: sreq[i] rising before edge k gives dreq[i] high after edge k+SYNC_STAGES-1, and dack[i] high one edge later. dvalid rises one edge after dreq[g] is seen low.
- Simultaneous requests are served in RR order from ptr; each channel is served at most once per CH grants while others are pending.
- Non-power-of-2 CH: ptr and g wrap at CH-1 -> 0.

Optional Feature:
- Macro: HS_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACK and increments each ACK cycle.
  - If the counter reaches TIMEOUT while dreq[g]=1: dack[g]<=0, err<=1 for one cycle, data discarded (no dvalid, dout/dch unchanged), ptr<=(g+1) mod CH, go to IDLE.
- Undefined: no counter; ACK waits indefinitely; err tied 0.

Test Plan:
- Single transfer, CH=4, SYNC_STAGES=2: sdata[ch2]=0xA5, raise sreq[2], drop it after dack[2] is seen -> one dvalid pulse, dout=0xA5, dch=2, dack[2] back to 0, didle=1.
- Contention: sreq[0], [1], [3] high together with data 0x11, 0x22, 0x44, ptr=0 -> dvalid pulses in order dch=0, 1, 3 with matching data; never two dack bits high.
- Fairness: after serving ch3 (ptr=0), ch3 and ch1 request together -> ch1 served before ch3.
- Backpressure: dbusy=1 while sreq[1] is high -> dack stays 0; release dbusy -> dack[1] rises next edge and the transfer completes normally.
- Reset mid-ACK: assert rst_n=0 while dack[2]=1 -> dack=0, dvalid=0, dout=0, didle=1 immediately; no stale dvalid after release.
- HS_TIMEOUT_EN, TIMEOUT=8: hold sreq[0] high indefinitely -> dack[0] drops 8 cycles into ACK, one err pulse, no dvalid.
